// File: rtl/dp_ram_be_if.sv
// dp_ram_be_if: bus bundle for the dp_ram_be dual-port RAM.
//   busy            : clear sweep in progress (RAM -> user)
//   a_en/a_we/a_be  : port A request, write qualifier, byte enables
//   a_addr/a_din    : port A word address and write data
//   a_dout/a_valid  : port A read data and its one-cycle valid pulse
//   b_en/b_addr     : port B (read-only) request and address
//   b_dout/b_valid  : port B read data and its one-cycle valid pulse
// modport master = user side, modport slave = RAM side.
interface dp_ram_be_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 16
);
  logic                  busy;
  logic                  a_en;
  logic                  a_we;
  logic [DATA_W/8-1:0]   a_be;
  logic [ADDR_W-1:0]     a_addr;
  logic [DATA_W-1:0]     a_din;
  logic [DATA_W-1:0]     a_dout;
  logic                  a_valid;
  logic                  b_en;
  logic [ADDR_W-1:0]     b_addr;
  logic [DATA_W-1:0]     b_dout;
  logic                  b_valid;

  modport master (
    input  busy,
    output a_en, a_we, a_be, a_addr, a_din,
    input  a_dout, a_valid,
    output b_en, b_addr,
    input  b_dout, b_valid
  );

  modport slave (
    output busy,
    input  a_en, a_we, a_be, a_addr, a_din,
    output a_dout, a_valid,
    input  b_en, b_addr,
    output b_dout, b_valid
  );
endinterface

// File: rtl/dp_ram_be.sv
// dp_ram_be: dual-port RAM, port A read/write with byte enables, port B
// read-only. Optional zeroing sweep after reset, selectable read-during-write
// policy and optional output register stage.
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : dp_ram_be_if slave modport (requests in, read data/valid/busy out)
// Parameters: DATA_W (multiple of 8), ADDR_W (depth 2^ADDR_W),
//   RDW_MODE (0 read-first, 1 write-first), OUT_REG (0/1 extra stage),
//   INIT_CLEAR (1 = zero array after reset release).
module dp_ram_be #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned RDW_MODE   = 0,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned INIT_CLEAR = 0
) (
  input  logic        clk,
  input  logic        reset,
  dp_ram_be_if.slave  bus
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_RUN, ST_CLEAR} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic                w_busy;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_run;
  logic                w_clr_wr;
  logic                w_a_acc;
  logic                w_a_wr;
  logic                w_b_acc;
  logic [DATA_W-1:0]   w_a_old;
  logic [DATA_W-1:0]   w_b_old;
  logic [DATA_W-1:0]   w_a_merged;
  logic [DATA_W-1:0]   w_a_rd;
  logic [DATA_W-1:0]   w_b_rd;

  logic                r_a_v1;
  logic                r_b_v1;
  logic [DATA_W-1:0]   r_a_d1;
  logic [DATA_W-1:0]   r_b_d1;

  // Controller: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
    else       r_state <= w_next;
  end

  // Controller: next state, leaves CLEAR after the last address is written
  always_comb begin
    w_next = r_state;
    if (r_state == ST_CLEAR && r_clr_addr == '1) w_next = ST_RUN;
  end

  // Controller: outputs
  always_comb begin
    w_busy = (r_state == ST_CLEAR);
  end

  assign bus.busy = w_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_clr_addr <= '0;
    else if (r_state == ST_CLEAR)  r_clr_addr <= r_clr_addr + 1'b1;
  end

  // Array writes are blocked while reset is held so contents survive reset.
  assign w_run    = (r_state == ST_RUN) && !reset;
  assign w_clr_wr = (r_state == ST_CLEAR) && !reset;
  assign w_a_acc  = w_run && bus.a_en;
  assign w_a_wr   = w_a_acc && bus.a_we;
  assign w_b_acc  = w_run && bus.b_en;

  assign w_a_old = r_mem[bus.a_addr];
  assign w_b_old = r_mem[bus.b_addr];

  // Merged word: enabled lanes take new data, others keep the old word.
  always_comb begin
    w_a_merged = w_a_old;
    for (int unsigned i = 0; i < NB; i++) begin
      if (w_a_wr && bus.a_be[i]) w_a_merged[8*i +: 8] = bus.a_din[8*i +: 8];
    end
  end

  // Port B sees the same write-first word as port A on an address collision.
  always_comb begin
    w_a_rd = (RDW_MODE != 0) ? w_a_merged : w_a_old;
    w_b_rd = w_b_old;
    if (RDW_MODE != 0 && w_a_wr && bus.b_addr == bus.a_addr) w_b_rd = w_a_merged;
  end

  always_ff @(posedge clk) begin
    if (w_clr_wr)    r_mem[r_clr_addr] <= '0;
    else if (w_a_wr) r_mem[bus.a_addr] <= w_a_merged;
  end

  // Read stage 1: data registers only load on an access so outputs hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_v1 <= 1'b0;
      r_b_v1 <= 1'b0;
      r_a_d1 <= '0;
      r_b_d1 <= '0;
    end else begin
      r_a_v1 <= w_a_acc;
      r_b_v1 <= w_b_acc;
      if (w_a_acc) r_a_d1 <= w_a_rd;
      if (w_b_acc) r_b_d1 <= w_b_rd;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              r_a_v2;
      logic              r_b_v2;
      logic [DATA_W-1:0] r_a_d2;
      logic [DATA_W-1:0] r_b_d2;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_a_v2 <= 1'b0;
          r_b_v2 <= 1'b0;
          r_a_d2 <= '0;
          r_b_d2 <= '0;
        end else begin
          r_a_v2 <= r_a_v1;
          r_b_v2 <= r_b_v1;
          if (r_a_v1) r_a_d2 <= r_a_d1;
          if (r_b_v1) r_b_d2 <= r_b_d1;
        end
      end

      assign bus.a_valid = r_a_v2;
      assign bus.a_dout  = r_a_d2;
      assign bus.b_valid = r_b_v2;
      assign bus.b_dout  = r_b_d2;
    end else begin : g_no_out_reg
      assign bus.a_valid = r_a_v1;
      assign bus.a_dout  = r_a_d1;
      assign bus.b_valid = r_b_v1;
      assign bus.b_dout  = r_b_d1;
    end
  endgenerate

endmodule

// File: tb/tb_dp_ram_be.sv
// tb_dp_ram_be: directed bench for dp_ram_be.
// Instance A: DATA_W=16, ADDR_W=4, read-first, latency 1, no clear.
// Instance B: DATA_W=16, ADDR_W=4, write-first, latency 2, clear after reset.
module tb_dp_ram_be;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk = ~clk;

  dp_ram_be_if #(.DATA_W(16), .ADDR_W(4)) ifa ();
  dp_ram_be_if #(.DATA_W(16), .ADDR_W(4)) ifb ();

  dp_ram_be #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0), .OUT_REG(0), .INIT_CLEAR(0))
    u_a (.clk(clk), .reset(rst_a), .bus(ifa));

  dp_ram_be #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(1), .INIT_CLEAR(1))
    u_b (.clk(clk), .reset(rst_b), .bus(ifb));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        a_en;
    logic        a_we;
    logic [1:0]  a_be;
    logic [3:0]  a_addr;
    logic [15:0] a_din;
    logic        b_en;
    logic [3:0]  b_addr;
    logic        av;
    logic [15:0] ad;
    logic        cad;
    logic        bv;
    logic [15:0] bd;
    logic        cbd;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic b_idle;
    ifb.a_en = 1'b0; ifb.a_we = 1'b0; ifb.a_be = '0; ifb.a_addr = '0;
    ifb.a_din = '0;  ifb.b_en = 1'b0; ifb.b_addr = '0;
  endtask

  // Runs while busy, firing writes/reads that must all be ignored.
  task automatic sweep(input int lim, output int n, output int nv);
    n = 0;
    nv = 0;
    while (ifb.busy && n < lim) begin
      ifb.a_en = 1'b1; ifb.a_we = 1'b1; ifb.a_be = '1;
      ifb.a_addr = n[3:0]; ifb.a_din = 16'hFFFF;
      ifb.b_en = 1'b1; ifb.b_addr = n[3:0];
      cyc;
      n++;
      if (ifb.a_valid || ifb.b_valid) nv++;
    end
    b_idle;
  endtask

  task automatic preload;
    for (int i = 0; i < 16; i++) begin
      ifb.a_en = 1'b1; ifb.a_we = 1'b1; ifb.a_be = '1;
      ifb.a_addr = i[3:0]; ifb.a_din = 16'h1100 + 16'(i);
      cyc;
    end
    b_idle;
    cyc;
    cyc;
  endtask

  // Back-to-back reads of all addresses on both ports, expecting zero.
  task automatic readall(input string tag);
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        ifb.a_en = 1'b1; ifb.a_we = 1'b0; ifb.a_addr = i[3:0];
        ifb.b_en = 1'b1; ifb.b_addr = 4'(15 - i);
      end else begin
        b_idle;
      end
      cyc;
      if (i == 0) begin
        chk({tag, " a_valid early"}, ifb.a_valid, 0);
      end else begin
        chk({tag, " a_valid"}, ifb.a_valid, 1);
        chk({tag, " a_dout"},  ifb.a_dout, 0);
        chk({tag, " b_valid"}, ifb.b_valid, 1);
        chk({tag, " b_dout"},  ifb.b_dout, 0);
      end
    end
    cyc;
    chk({tag, " a_valid end"}, ifb.a_valid, 0);
    chk({tag, " b_valid end"}, ifb.b_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int nv;
    int nv2;

    //            en we be     addr   din       ben baddr  av ad        cad bv bd        cbd
    vt[0]  = '{1, 1, 2'b11, 4'd3,  16'hBEEF, 0, 4'd0,  1, 16'h0000, 0, 0, 16'h0000, 1};
    vt[1]  = '{0, 0, 2'b00, 4'd0,  16'h0000, 1, 4'd3,  0, 16'h0000, 0, 1, 16'hBEEF, 1};
    vt[2]  = '{1, 1, 2'b01, 4'd3,  16'h1234, 0, 4'd0,  1, 16'hBEEF, 1, 0, 16'hBEEF, 1};
    vt[3]  = '{1, 0, 2'b00, 4'd3,  16'h0000, 1, 4'd3,  1, 16'hBE34, 1, 1, 16'hBE34, 1};
    vt[4]  = '{1, 1, 2'b11, 4'd5,  16'h1111, 0, 4'd0,  1, 16'h0000, 0, 0, 16'hBE34, 1};
    vt[5]  = '{1, 1, 2'b11, 4'd5,  16'h2222, 1, 4'd5,  1, 16'h1111, 1, 1, 16'h1111, 1};
    vt[6]  = '{1, 0, 2'b00, 4'd5,  16'h0000, 1, 4'd3,  1, 16'h2222, 1, 1, 16'hBE34, 1};
    vt[7]  = '{1, 1, 2'b00, 4'd5,  16'hFFFF, 1, 4'd5,  1, 16'h2222, 1, 1, 16'h2222, 1};
    vt[8]  = '{0, 0, 2'b00, 4'd0,  16'h0000, 0, 4'd0,  0, 16'h2222, 1, 0, 16'h2222, 1};
    vt[9]  = '{1, 1, 2'b10, 4'd5,  16'hAB00, 1, 4'd5,  1, 16'h2222, 1, 1, 16'h2222, 1};
    vt[10] = '{1, 0, 2'b00, 4'd5,  16'h0000, 0, 4'd0,  1, 16'hAB22, 1, 0, 16'h2222, 1};
    vt[11] = '{1, 1, 2'b11, 4'd15, 16'h5A5A, 1, 4'd15, 1, 16'h0000, 0, 1, 16'h0000, 0};
    vt[12] = '{1, 0, 2'b00, 4'd15, 16'h0000, 1, 4'd15, 1, 16'h5A5A, 1, 1, 16'h5A5A, 1};
    vt[13] = '{0, 1, 2'b11, 4'd15, 16'h0000, 0, 4'd0,  0, 16'h5A5A, 1, 0, 16'h5A5A, 1};
    vt[14] = '{1, 0, 2'b00, 4'd15, 16'h0000, 0, 4'd0,  1, 16'h5A5A, 1, 0, 16'h5A5A, 1};

    ifa.a_en = 1'b0; ifa.a_we = 1'b0; ifa.a_be = '0; ifa.a_addr = '0;
    ifa.a_din = '0;  ifa.b_en = 1'b0; ifa.b_addr = '0;
    b_idle;

    repeat (2) cyc;
    chk("rst A a_dout",  ifa.a_dout, 0);
    chk("rst A a_valid", ifa.a_valid, 0);
    chk("rst A b_dout",  ifa.b_dout, 0);
    chk("rst A b_valid", ifa.b_valid, 0);
    chk("rst A busy",    ifa.busy, 0);
    chk("rst B busy",    ifb.busy, 1);
    chk("rst B a_valid", ifb.a_valid, 0);

    // Instance A vector table
    rst_a = 1'b0;
    cyc;
    chk("A busy run", ifa.busy, 0);
    for (int i = 0; i < 15; i++) begin
      ifa.a_en = vt[i].a_en; ifa.a_we = vt[i].a_we; ifa.a_be = vt[i].a_be;
      ifa.a_addr = vt[i].a_addr; ifa.a_din = vt[i].a_din;
      ifa.b_en = vt[i].b_en; ifa.b_addr = vt[i].b_addr;
      cyc;
      chk($sformatf("vec%0d a_valid", i), ifa.a_valid, vt[i].av);
      if (vt[i].cad) chk($sformatf("vec%0d a_dout", i), ifa.a_dout, vt[i].ad);
      chk($sformatf("vec%0d b_valid", i), ifa.b_valid, vt[i].bv);
      if (vt[i].cbd) chk($sformatf("vec%0d b_dout", i), ifa.b_dout, vt[i].bd);
    end
    ifa.a_en = 1'b0; ifa.a_we = 1'b0; ifa.b_en = 1'b0;

    // Instance B: first sweep after reset release
    rst_b = 1'b0;
    sweep(40, n, nv);
    chk("clr1 busy cycles", n, 16);
    repeat (2) begin
      cyc;
      if (ifb.a_valid || ifb.b_valid) nv++;
    end
    chk("clr1 valid during busy", nv, 0);
    readall("clr1");

    // Write-first collisions, full and partial byte enables
    preload;
    ifb.a_en = 1'b1; ifb.a_we = 1'b1; ifb.a_be = 2'b11; ifb.a_addr = 4'd5;
    ifb.a_din = 16'h2222; ifb.b_en = 1'b1; ifb.b_addr = 4'd5;
    cyc;
    chk("wf lat a_valid", ifb.a_valid, 0);
    chk("wf lat b_valid", ifb.b_valid, 0);
    ifb.a_be = 2'b01; ifb.a_addr = 4'd6; ifb.a_din = 16'h00AB; ifb.b_addr = 4'd6;
    cyc;
    chk("wf5 a_valid", ifb.a_valid, 1);
    chk("wf5 a_dout",  ifb.a_dout, 16'h2222);
    chk("wf5 b_valid", ifb.b_valid, 1);
    chk("wf5 b_dout",  ifb.b_dout, 16'h2222);
    b_idle;
    cyc;
    chk("wf6 a_dout",  ifb.a_dout, 16'h11AB);
    chk("wf6 b_valid", ifb.b_valid, 1);
    chk("wf6 b_dout",  ifb.b_dout, 16'h11AB);
    cyc;
    chk("wf idle a_valid", ifb.a_valid, 0);
    chk("wf idle b_valid", ifb.b_valid, 0);
    chk("wf hold b_dout",  ifb.b_dout, 16'h11AB);

    // Consecutive reads 0,1,2 on port B with latency 2
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        ifb.b_en = 1'b1; ifb.b_addr = i[3:0];
      end else begin
        b_idle;
      end
      cyc;
      if (i >= 1 && i <= 3) begin
        chk($sformatf("seq%0d b_valid", i), ifb.b_valid, 1);
        chk($sformatf("seq%0d b_dout", i), ifb.b_dout, 16'h1100 + 16'(i - 1));
      end else begin
        chk($sformatf("seq%0d b_valid", i), ifb.b_valid, 0);
      end
    end
    chk("seq hold b_dout", ifb.b_dout, 16'h1102);

    // Reset with nonzero contents, sweep must zero them
    rst_b = 1'b1;
    cyc;
    chk("rst2 busy",    ifb.busy, 1);
    chk("rst2 a_dout",  ifb.a_dout, 0);
    chk("rst2 b_dout",  ifb.b_dout, 0);
    chk("rst2 b_valid", ifb.b_valid, 0);
    rst_b = 1'b0;
    sweep(40, n, nv);
    chk("clr2 busy cycles", n, 16);
    repeat (2) begin
      cyc;
      if (ifb.a_valid || ifb.b_valid) nv++;
    end
    chk("clr2 valid during busy", nv, 0);
    readall("clr2");

    // Read in flight at reset, then reset again at clear address 7
    preload;
    ifb.b_en = 1'b1; ifb.b_addr = 4'd3;
    cyc;
    b_idle;
    rst_b = 1'b1;
    #1;
    chk("flush b_valid", ifb.b_valid, 0);
    cyc;
    rst_b = 1'b0;
    sweep(7, n, nv);
    chk("clr3 partial cycles", n, 7);
    chk("clr3 busy at addr7", ifb.busy, 1);
    rst_b = 1'b1;
    cyc;
    rst_b = 1'b0;
    sweep(40, n, nv2);
    chk("clr3 restart busy cycles", n, 16);
    repeat (2) begin
      cyc;
      if (ifb.a_valid || ifb.b_valid) nv2++;
    end
    chk("clr3 in-flight valid", nv + nv2, 0);
    readall("clr3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
